axi_slave_ram: RTL and testbench

Synthesizable AXI4 slave memory: the responder end of the core's instruction and data AXI4 master ports. It replaces the behavioural slave BFMs so the core can run on hardware and in gate-level simulation. It holds a single-port, word-organised synchronous RAM and serves INCR/FIXED bursts, one transaction at a time, with alternating read/write arbitration.

---
 rtl/axi_slave_ram.sv | 185 ++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a single-port word RAM; one burst at a time, alternating R/W grant.
// Optional out-of-range DECERR checking: define AXI_SLAVE_RAM_BOUNDARY_CHECK_EN.
module axi_slave_ram #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_MEM_ADDR_WIDTH = 12
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [C_AXI_ID_WIDTH-1:0]   AWID,
  input  logic [31:0]                 AWADDR,
  input  logic [7:0]                  AWLEN,
  input  logic [2:0]                  AWSIZE,
  input  logic [1:0]                  AWBURST,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                        WLAST,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]   ARID,
  input  logic [31:0]                 ARADDR,
  input  logic [7:0]                  ARLEN,
  input  logic [2:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   RID,
  output logic [C_AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY
);
  localparam int NB    = C_AXI_DATA_WIDTH / 8;
  localparam int IW    = C_MEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [2:0] {IDLE, AGRANT, WRITE, WRESP, READ} state_t;
  state_t state, state_nxt;

  logic                        wr_q;      // type of the last/current grant; 1 after reset => read first
  logic [C_AXI_ID_WIDTH-1:0]   id_q;
  logic [31:0]                 addr_q;
  logic [7:0]                  len_q;
  logic                        fixed_q;
  logic [8:0]                  beat_q;
  logic                        slverr_q, decerr_q;
  logic                        beat_oor, beat_last;
  logic                        w_hs, r_hs, rd_issue, ram_we;
  logic [IW-1:0]               idx;

  logic                        ram_vld, pend_last, pend_dec;
  logic [C_AXI_DATA_WIDTH-1:0] ram_q;
  logic [C_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0][C_AXI_DATA_WIDTH-1:0] buf_data;
  logic [1:0]                  buf_last, buf_dec;
  logic                        buf_wp, buf_rp;
  logic [1:0]                  buf_cnt, occ;

  assign idx       = addr_q[IW+1:2];
  assign beat_last = (beat_q == {1'b0, len_q});
  assign w_hs      = (state == WRITE) && WVALID;
  assign r_hs      = RVALID && RREADY;

`ifdef AXI_SLAVE_RAM_BOUNDARY_CHECK_EN
  assign beat_oor = |addr_q[31:IW+2];
`else
  assign beat_oor = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{AWSIZE, ARSIZE, addr_q[1:0], addr_q[31:IW+2]};

  // Prefetch credit: buffered + in-flight beats, net of this cycle's pop, must stay below 2.
  assign occ      = buf_cnt + {1'b0, ram_vld} - {1'b0, r_hs};
  assign rd_issue = (state == READ) && (beat_q <= {1'b0, len_q}) && (occ < 2'd2);
  assign ram_we   = w_hs && !beat_oor;

  always_ff @(posedge ACLK) begin
    if (ram_we)
      for (int b = 0; b < NB; b++)
        if (WSTRB[b]) mem[idx][8*b +: 8] <= WDATA[8*b +: 8];
    if (rd_issue) ram_q <= mem[idx];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (AWVALID || ARVALID) state_nxt = AGRANT;
      AGRANT:  state_nxt = wr_q ? WRITE : READ;
      WRITE:   if (w_hs && beat_last) state_nxt = WRESP;
      WRESP:   if (BREADY) state_nxt = IDLE;
      READ:    if (r_hs && RLAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (state == AGRANT) && wr_q;
    ARREADY = (state == AGRANT) && !wr_q;
    WREADY  = (state == WRITE);
    BVALID  = (state == WRESP);
    RVALID  = (state == READ) && (buf_cnt != 2'd0);
    BRESP   = decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);
  end

  assign BID   = id_q;
  assign RID   = id_q;
  assign RDATA = buf_data[buf_rp];
  assign RLAST = buf_last[buf_rp];
  assign RRESP = buf_dec[buf_rp] ? 2'b11 : 2'b00;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_q      <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      fixed_q   <= 1'b0;
      beat_q    <= '0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      ram_vld   <= 1'b0;
      pend_last <= 1'b0;
      pend_dec  <= 1'b0;
      buf_data  <= '0;
      buf_last  <= '0;
      buf_dec   <= '0;
      buf_wp    <= 1'b0;
      buf_rp    <= 1'b0;
      buf_cnt   <= '0;
    end else begin
      if (state == IDLE && (AWVALID || ARVALID))
        wr_q <= AWVALID && (!ARVALID || !wr_q);

      if (state == AGRANT) begin
        id_q     <= wr_q ? AWID : ARID;
        addr_q   <= wr_q ? AWADDR : ARADDR;
        len_q    <= wr_q ? AWLEN : ARLEN;
        fixed_q  <= (wr_q ? AWBURST : ARBURST) == 2'b00;
        beat_q   <= '0;
        slverr_q <= 1'b0;
        decerr_q <= 1'b0;
      end

      // One beat advance per accepted W beat or issued RAM read; WRAP walks like INCR.
      if (w_hs || rd_issue) begin
        beat_q <= beat_q + 9'd1;
        if (!fixed_q) addr_q <= addr_q + 32'd4;
      end

      if (w_hs) begin
        if (WLAST != beat_last) slverr_q <= 1'b1;
        if (beat_oor)           decerr_q <= 1'b1;
      end

      ram_vld <= rd_issue;
      if (rd_issue) begin
        pend_last <= beat_last;
        pend_dec  <= beat_oor;
      end

      if (ram_vld) begin
        buf_data[buf_wp] <= pend_dec ? '0 : ram_q;
        buf_last[buf_wp] <= pend_last;
        buf_dec[buf_wp]  <= pend_dec;
        buf_wp           <= ~buf_wp;
      end
      if (r_hs) buf_rp <= ~buf_rp;
      buf_cnt <= buf_cnt + {1'b0, ram_vld} - {1'b0, r_hs};
    end
  end
endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: handshake timing, bursts, arbitration, backpressure, reset.
module tb_axi_slave_ram;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [0:0]  AWID = '0, ARID = '0, BID, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
  logic [1:0]  AWBURST = 2'b01, ARBURST = 2'b01, BRESP, RRESP;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY;
  logic        BVALID, BREADY = 0, ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;

  axi_slave_ram dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  logic [31:0] rdat [8];
  logic [1:0]  rrsp [8];
  logic        rlst [8];
  int          rd_lat, rd_span, aw_wait;
  logic [1:0]  bresp_q;
  logic [0:0]  bid_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    ARESETN = 0; AWVALID = 0; ARVALID = 0; WVALID = 0; BREADY = 0; RREADY = 0;
    cyc(); cyc();
    ARESETN = 1;
    cyc();
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                        input logic [0:0] id);
    AWADDR = a; AWLEN = len; AWBURST = burst; AWID = id; AWVALID = 1;
    aw_wait = 0;
    while (!AWREADY && aw_wait < 50) begin cyc(); aw_wait++; end
    if (!AWREADY) check("aw_timeout", 0, 1);
    cyc();
    AWVALID = 0;
  endtask

  task automatic w_data(input int n, input int last_at);
    int g;
    for (int i = 0; i < n; i++) begin
      WVALID = 1; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == last_at);
      g = 0;
      while (!WREADY && g < 50) begin cyc(); g++; end
      if (!WREADY) check("w_timeout", 0, 1);
      cyc();
    end
    WVALID = 0; WLAST = 0;
  endtask

  task automatic b_resp();
    int g;
    BREADY = 1;
    check("bvalid_after_last_w", BVALID, 1);
    g = 0;
    while (!BVALID && g < 50) begin cyc(); g++; end
    bresp_q = BRESP; bid_q = BID;
    cyc();
    BREADY = 0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input int last_at);
    aw_req(a, len, burst, 1'b1);
    w_data(int'(len) + 1, last_at);
    b_resp();
  endtask

  task automatic ar_req(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    int g;
    ARADDR = a; ARLEN = len; ARBURST = burst; ARID = 1'b1; ARVALID = 1;
    g = 0;
    while (!ARREADY && g < 50) begin cyc(); g++; end
    if (!ARREADY) check("ar_timeout", 0, 1);
    cyc();
    ARVALID = 0;
  endtask

  // Collect len+1 beats with RREADY driven from pat (bit k%16 on cycle k).
  task automatic r_collect(input int len, input logic [15:0] pat);
    int t, beats, first_t;
    logic stalled;
    logic [31:0] held;
    t = 0; beats = 0; first_t = -1; stalled = 0; held = '0;
    while (beats <= len && t < 300) begin
      RREADY = pat[t % 16];
      if (RVALID) begin
        if (first_t < 0) first_t = t;
        if (stalled) check("r_stable", RDATA, held);
        if (RREADY) begin
          rdat[beats] = RDATA; rrsp[beats] = RRESP; rlst[beats] = RLAST;
          if (beats == len) rd_span = t - first_t;
          beats++; stalled = 0;
        end else begin
          stalled = 1; held = RDATA;
        end
      end
      cyc(); t++;
    end
    RREADY = 0;
    if (beats <= len) check("r_timeout", beats, len + 1);
    rd_lat = first_t + 1;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [15:0] pat);
    ar_req(a, len, burst);
    r_collect(int'(len), pat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin wd[i] = '0; ws[i] = 4'hF; end
    #1;
    // Reset state
    cyc();
    check("rst_ready", {AWREADY, ARREADY, WREADY}, 3'b000);
    check("rst_valid", {BVALID, RVALID}, 2'b00);
    check("rst_resp",  {BRESP, RRESP, RLAST}, 5'b0);
    check("rst_rdata", RDATA, 32'h0);
    ARESETN = 1;
    cyc();

    // Single write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    aw_req(32'h10, 8'd0, 2'b01, 1'b1);
    check("aw_lat", aw_wait, 1);
    check("wready_first", WREADY, 1);
    w_data(1, 0);
    b_resp();
    check("single_bresp", bresp_q, 2'b00);
    check("single_bid", bid_q, 1'b1);
    axi_read(32'h10, 8'd0, 2'b01, 16'hFFFF);
    check("single_rdata", rdat[0], 32'hDEADBEEF);
    check("single_rlast", rlst[0], 1);
    check("single_rresp", rrsp[0], 2'b00);
    check("single_rlat", rd_lat, 3);

    // INCR burst with byte strobes over a prefilled word
    wd[0] = 32'hAAAAAAAA;
    axi_write(32'h8, 8'd0, 2'b01, 0);
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'h3; ws[3] = 4'hF;
    axi_write(32'h0, 8'd3, 2'b01, 3);
    check("incr_bresp", bresp_q, 2'b00);
    ws[2] = 4'hF;
    axi_read(32'h0, 8'd3, 2'b01, 16'hFFFF);
    check("incr_d0", rdat[0], 32'h11111111);
    check("incr_d1", rdat[1], 32'h22222222);
    check("incr_d2", rdat[2], 32'hAAAA3333);
    check("incr_d3", rdat[3], 32'h44444444);
    check("incr_rlast", {rlst[3], rlst[2], rlst[1], rlst[0]}, 4'b1000);
    check("incr_no_bubble", rd_span, 3);

    // Simultaneous requests after reset: read first, then alternate
    do_reset();
    AWADDR = 32'h40; AWLEN = 0; AWBURST = 2'b01; AWID = 1; AWVALID = 1;
    ARADDR = 32'h10; ARLEN = 0; ARBURST = 2'b01; ARID = 1; ARVALID = 1;
    cyc();
    check("sim1_grant", {ARREADY, AWREADY}, 2'b10);
    cyc(); ARVALID = 0;
    r_collect(0, 16'hFFFF);
    check("sim1_rdata", rdat[0], 32'hDEADBEEF);
    wd[0] = 32'h5A5A5A5A;
    aw_req(32'h40, 8'd0, 2'b01, 1'b1);
    w_data(1, 0);
    b_resp();
    check("sim1_bresp", bresp_q, 2'b00);
    AWADDR = 32'h44; AWVALID = 1;
    ARADDR = 32'h40; ARVALID = 1;
    begin
      int g;
      g = 0;
      while (!ARREADY && !AWREADY && g < 50) begin cyc(); g++; end
    end
    check("sim2_grant", {ARREADY, AWREADY}, 2'b10);
    cyc(); ARVALID = 0;
    r_collect(0, 16'hFFFF);
    check("sim2_rdata", rdat[0], 32'h5A5A5A5A);
    wd[0] = 32'h12345678;
    aw_req(32'h44, 8'd0, 2'b01, 1'b1);
    w_data(1, 0);
    b_resp();
    check("sim2_bresp", bresp_q, 2'b00);

    // Read backpressure on an 8-beat burst
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE0000 + i; ws[i] = 4'hF; end
    axi_write(32'h100, 8'd7, 2'b01, 7);
    axi_read(32'h100, 8'd7, 2'b01, 16'h9999);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_d%0d", i), rdat[i], 32'hC0DE0000 + i);
      check($sformatf("bp_last%0d", i), rlst[i], (i == 7) ? 1 : 0);
    end

    // WLAST mismatch: full length from AWLEN, SLVERR
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
    axi_write(32'h200, 8'd3, 2'b01, 2);
    check("wlast_bresp", bresp_q, 2'b10);
    axi_read(32'h200, 8'd3, 2'b01, 16'hFFFF);
    for (int i = 0; i < 4; i++) check($sformatf("wlast_d%0d", i), rdat[i], 32'hA0 + i);

    // FIXED burst: all beats to one word, last wins
    wd[0] = 1; wd[1] = 2; wd[2] = 3;
    axi_write(32'h20, 8'd2, 2'b00, 2);
    check("fixed_bresp", bresp_q, 2'b00);
    axi_read(32'h20, 8'd0, 2'b01, 16'hFFFF);
    check("fixed_word8", rdat[0], 32'h3);

    // Reset in the middle of a read burst
    ar_req(32'h100, 8'd7, 2'b01);
    RREADY = 1;
    begin
      int g;
      g = 0;
      while (!RVALID && g < 50) begin cyc(); g++; end
    end
    cyc(); cyc();
    ARESETN = 0;
    #1;
    check("midrst_rvalid", RVALID, 0);
    check("midrst_rdata", RDATA, 32'h0);
    check("midrst_ready", {ARREADY, AWREADY}, 2'b00);
    cyc();
    RREADY = 0; ARESETN = 1;
    cyc();
    axi_read(32'h10, 8'd0, 2'b01, 16'hFFFF);
    check("postrst_rdata", rdat[0], 32'hDEADBEEF);
    check("postrst_rlat", rd_lat, 3);

`ifdef AXI_SLAVE_RAM_BOUNDARY_CHECK_EN
    axi_read(32'h4000, 8'd0, 2'b01, 16'hFFFF);
    check("oor_rdata", rdat[0], 32'h0);
    check("oor_rresp", rrsp[0], 2'b11);
    wd[0] = 32'hFFFFFFFF;
    axi_write(32'h4000, 8'd0, 2'b01, 0);
    check("oor_bresp", bresp_q, 2'b11);
    axi_read(32'h0, 8'd0, 2'b01, 16'hFFFF);
    check("oor_no_alias_write", rdat[0], 32'h11111111);
`else
    axi_read(32'h4010, 8'd0, 2'b01, 16'hFFFF);
    check("alias_rdata", rdat[0], 32'hDEADBEEF);
    check("alias_rresp", rrsp[0], 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
